// File: rtl/reg_arbiter.sv
// Round-robin arbiter granting N_REQ requesters write access to one shared register,
// with readback verification and a bounded number of write retries.
module reg_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic                   busy,
  output logic                   reg_en,
  output logic [WIDTH-1:0]       reg_in,
  input  logic [WIDTH-1:0]       reg_out
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RW = 3;

  typedef enum logic [2:0] {IDLE, GRANT, WRITE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    winner_q, winner_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             err_flag_q, err_flag_d;

  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             reg_en_q, reg_en_d;
  logic [WIDTH-1:0] reg_in_q, reg_in_d;

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;

  logic [WIDTH-1:0] wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Walk offsets from the far end down so the closest match to ptr wins last.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_w;
    idx        = 0;
    idx_w      = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = PW'(idx);
      if (req[idx_w]) begin
        pick_valid = 1'b1;
        pick_idx   = idx_w;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    data_d     = data_q;
    retry_d    = retry_q;
    err_flag_d = err_flag_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          winner_d = pick_idx;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        data_d     = wdata_arr[winner_q];
        retry_d    = '0;
        err_flag_d = 1'b0;
        state_d    = WRITE;
      end
      WRITE: state_d = CHECK;
      CHECK: begin
        if (reg_out == data_q) begin
          state_d = DONE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          state_d = WRITE;
        end else begin
          err_flag_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        ptr_d   = (winner_q == PW'(N_REQ - 1)) ? '0 : winner_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    grant_d = '0;
    ack_d   = '0;
    if (state_d != IDLE) grant_d[winner_d] = 1'b1;
    if (state_d == DONE) ack_d[winner_d] = 1'b1;
    err_d    = (state_d == DONE) && err_flag_d;
    busy_d   = (state_d != IDLE);
    reg_en_d = (state_d == WRITE);
    reg_in_d = (state_d != IDLE) ? data_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      winner_q   <= '0;
      data_q     <= '0;
      retry_q    <= '0;
      err_flag_q <= 1'b0;
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      reg_en_q   <= 1'b0;
      reg_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      data_q     <= data_d;
      retry_q    <= retry_d;
      err_flag_q <= err_flag_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      reg_en_q   <= reg_en_d;
      reg_in_q   <= reg_in_d;
    end
  end

  assign grant  = grant_q;
  assign ack    = ack_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign reg_en = reg_en_q;
  assign reg_in = reg_in_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter: a cycle table for the basic flow plus
// hand-written sequences for round-robin order, retries and mid-write reset.
module tb_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic        reg_en;
  logic [7:0]  reg_in;
  logic [7:0]  reg_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;   // 0 ideal register, 1 stuck at zero, 2 corrupt first write
  int write_cnt = 0;
  int grant_cyc = 0;
  logic [7:0] reg_model = 8'h00;

  reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_RETRY(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
    .grant  (grant),
    .ack    (ack),
    .err    (err),
    .busy   (busy),
    .reg_en (reg_en),
    .reg_in (reg_in),
    .reg_out(reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign reg_out = reg_model;

  always @(posedge clk) begin
    if (!busy) write_cnt <= 0;
    else if (reg_en) write_cnt <= write_cnt + 1;
    if (reg_en) begin
      case (mode)
        1:       reg_model <= 8'h00;
        2:       reg_model <= (write_cnt == 0) ? ~reg_in : reg_in;
        default: reg_model <= reg_in;
      endcase
    end
  end

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] e_grant;
    logic [3:0] e_ack;
    logic       e_err;
    logic       e_busy;
    logic       e_en;
    logic [7:0] e_in;
  } vec_t;

  vec_t vecs [18];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Follow one transaction from its GRANT cycle to DONE, then step into IDLE.
  task automatic txn(input string name, input logic [3:0] exp_g, input int exp_en,
                     input int exp_len, input logic exp_err);
    int n;
    int len;
    int en;
    logic [3:0] g;
    logic held;
    n = 0;
    while (grant == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check({name, " grant"}, 32'(grant), 32'(exp_g));
    g = grant;
    grant_cyc = cyc;
    len = 1;
    en = reg_en ? 1 : 0;
    held = 1'b1;
    while (ack == 4'b0 && len < 20) begin
      tick();
      len++;
      if (reg_en) en++;
      if (grant != g) held = 1'b0;
    end
    check({name, " length"}, 32'(len), 32'(exp_len));
    check({name, " reg_en pulses"}, 32'(en), 32'(exp_en));
    check({name, " ack"}, 32'(ack), 32'(exp_g));
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " grant held"}, 32'(held), 32'd1);
    $display("txn %s: grant=%b len=%0d writes=%0d err=%b", name, g, len, en, err);
    tick();
  endtask

  initial begin
    int n;
    int prev;
    logic [3:0] rr_exp [5];

    rst_n = 1'b0;
    req   = 4'b0;
    wdata = {8'h44, 8'h33, 8'h22, 8'hA5};
    mode  = 0;

    //           rst req  grant ack  err busy en  reg_in
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[4]  = '{1'b1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b1, 4'h0, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[6]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 4'h3, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[9]  = '{1'b1, 4'h3, 4'h2, 4'h0, 1'b0, 1'b1, 1'b1, 8'h22};
    vecs[10] = '{1'b1, 4'h3, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 8'h22};
    vecs[11] = '{1'b1, 4'h3, 4'h2, 4'h2, 1'b0, 1'b1, 1'b0, 8'h22};
    vecs[12] = '{1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 4'h3, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 8'h22};
    vecs[14] = '{1'b1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[15] = '{1'b1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[16] = '{1'b1, 4'h0, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[17] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 18; i++) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      tick();
      check($sformatf("vec%0d {grant,ack,err,busy,en,in}", i),
            32'({grant, ack, err, busy, reg_en, reg_in}),
            32'({vecs[i].e_grant, vecs[i].e_ack, vecs[i].e_err, vecs[i].e_busy,
                 vecs[i].e_en, vecs[i].e_in}));
      $display("vec %0d: req=%b grant=%b ack=%b err=%b busy=%b reg_en=%b reg_in=%h",
               i, req, grant, ack, err, busy, reg_en, reg_in);
    end

    // ptr is 1 here: requester 3 beats 0, then 0 follows after wrap-around.
    req = 4'b1001;
    txn("rr_from_ptr1_first", 4'b1000, 1, 4, 1'b0);
    txn("rr_from_ptr1_wrap", 4'b0001, 1, 4, 1'b0);
    req = 4'b0000;

    // All requesters held from ptr=0: strict rotation, 5 cycles between grants.
    do_reset();
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;
    req  = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      txn($sformatf("rr_all_%0d", i), rr_exp[i], 1, 4, 1'b0);
      if (i > 0) check($sformatf("rr_all_%0d spacing", i), 32'(grant_cyc - prev), 32'd5);
      prev = grant_cyc;
    end
    req = 4'b0000;

    // Register stuck at zero: all retries used, err with ack.
    mode  = 1;
    wdata = {8'h44, 8'h33, 8'h22, 8'h3C};
    req   = 4'b0001;
    txn("stuck_zero", 4'b0001, 3, 8, 1'b1);
    req = 4'b0000;

    // Only the first write is corrupted: one retry, no err.
    mode  = 2;
    wdata = {8'h44, 8'h77, 8'h22, 8'h3C};
    req   = 4'b0100;
    txn("one_retry", 4'b0100, 2, 6, 1'b0);
    req = 4'b0000;

    // Reset during WRITE aborts, and arbitration restarts from ptr=0.
    mode = 0;
    do_reset();
    req = 4'b0001;
    txn("pre_reset", 4'b0001, 1, 4, 1'b0);
    req = 4'b0011;
    n = 0;
    while (!reg_en && n < 20) begin
      tick();
      n++;
    end
    check("mid_write grant", 32'(grant), 32'(4'b0010));
    rst_n = 1'b0;
    tick();
    check("reset_in_write outputs", 32'({grant, ack, err, busy, reg_en, reg_in}), 32'd0);
    $display("reset in WRITE: grant=%b ack=%b busy=%b reg_en=%b reg_in=%h",
             grant, ack, busy, reg_en, reg_in);
    rst_n = 1'b1;
    txn("post_reset_regrant", 4'b0001, 1, 4, 1'b0);
    req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
